// File: rtl/gpu_pkg.sv
// Shared GPU front-end types and default geometry for the triangle setup stage
// and the rasteriser that consumes its results.
package gpu_pkg;

   localparam int XW_DEF       = 9;
   localparam int YW_DEF       = 8;
   localparam int SCREEN_W_DEF = 320;
   localparam int SCREEN_H_DEF = 240;

   // Vertex packed as {x, y}, both unsigned screen coordinates
   typedef struct packed {
      logic [XW_DEF-1:0] x;
      logic [YW_DEF-1:0] y;
   } vertex_t;

   // Setup result handed to the rasteriser
   typedef struct packed {
      logic signed [YW_DEF:0]        a1, a2, a3;
      logic signed [XW_DEF:0]        b1, b2, b3;
      logic signed [XW_DEF+YW_DEF:0] c1, c2, c3;
      logic [XW_DEF+YW_DEF+1:0]      area2;
      logic [XW_DEF-1:0]             bbxi, bbxf;
      logic [YW_DEF-1:0]             bbyi, bbyf;
   } setup_result_t;

endpackage

// File: rtl/tri_edge_coef.sv
// One edge i->j of the triangle: A and B in the first stage together with the
// two cross products, C in the second stage. Products are registered on their
// own so the multipliers map onto DSP blocks with their output registers.
module tri_edge_coef
   import gpu_pkg::*;
#(
   parameter int XW = XW_DEF,
   parameter int YW = YW_DEF
) (
   input  logic                 clk,
   input  logic                 en,
   input  logic [XW-1:0]        xi,
   input  logic [YW-1:0]        yi,
   input  logic [XW-1:0]        xj,
   input  logic [YW-1:0]        yj,
   output logic signed [YW:0]   a,
   output logic signed [XW:0]   b,
   output logic signed [XW+YW:0] c
);

   logic signed [YW:0]    a_s1_reg, a_s2_reg;
   logic signed [XW:0]    b_s1_reg, b_s2_reg;
   logic [XW+YW-1:0]      p_ij_reg, p_ji_reg;
   logic signed [XW+YW:0] c_reg;

   // Stage 1: zero-extended differences and the two unsigned cross products
   always_ff @(posedge clk) begin
      if (en) begin
         a_s1_reg <= $signed({1'b0, yi}) - $signed({1'b0, yj});
         b_s1_reg <= $signed({1'b0, xj}) - $signed({1'b0, xi});
         p_ij_reg <= (XW+YW)'(xi) * (XW+YW)'(yj);
         p_ji_reg <= (XW+YW)'(xj) * (XW+YW)'(yi);
      end
   end

   // Stage 2: C from the registered products, A/B carried alongside
   always_ff @(posedge clk) begin
      if (en) begin
         a_s2_reg <= a_s1_reg;
         b_s2_reg <= b_s1_reg;
         c_reg    <= $signed({1'b0, p_ij_reg}) - $signed({1'b0, p_ji_reg});
      end
   end

   assign a = a_s2_reg;
   assign b = b_s2_reg;
   assign c = c_reg;

endmodule

// File: rtl/tri_setup.sv
// Triangle setup: edge coefficients, doubled area and clipped bounding box,
// three register stages under one global advance, with in-line culling of
// back-facing, degenerate and off-screen triangles.
module tri_setup
   import gpu_pkg::*;
#(
   parameter int XW       = XW_DEF,
   parameter int YW       = YW_DEF,
   parameter int SCREEN_W = SCREEN_W_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF,
   parameter bit CULL_BACK = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [XW+YW-1:0]       v1,
   input  logic [XW+YW-1:0]       v2,
   input  logic [XW+YW-1:0]       v3,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [YW:0]     a1, a2, a3,
   output logic signed [XW:0]     b1, b2, b3,
   output logic signed [XW+YW:0]  c1, c2, c3,
   output logic [XW+YW+1:0]       area2,
   output logic [XW-1:0]          bbxi, bbxf,
   output logic [YW-1:0]          bbyi, bbyf,
   output logic                   cull_pulse,
   output logic [15:0]            cull_count
);

   localparam int CW = XW + YW + 1;
   localparam int SW = XW + YW + 2;
   localparam logic [XW-1:0] X_LAST = XW'(SCREEN_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_H - 1);
   localparam logic [XW:0]   X_LIM  = (XW+1)'(SCREEN_W);
   localparam logic [YW:0]   Y_LIM  = (YW+1)'(SCREEN_H);

   logic adv;
   logic out_valid_reg, cull_pulse_reg, s1_valid_reg, s2_valid_reg;
   logic [15:0] cull_count_reg;

   logic [XW-1:0] vx [3];
   logic [YW-1:0] vy [3];
   logic signed [YW:0]   a_s2 [3];
   logic signed [XW:0]   b_s2 [3];
   logic signed [CW-1:0] c_s2 [3];

   logic [XW-1:0] min_x_next, max_x_next, min_x_reg, max_x_reg;
   logic [YW-1:0] min_y_next, max_y_next, min_y_reg, max_y_reg;
   logic [XW-1:0] bbxi_s2_reg, bbxf_s2_reg;
   logic [YW-1:0] bbyi_s2_reg, bbyf_s2_reg;
   logic          off_s2_reg;

   logic signed [SW-1:0] s_sum;
   logic                 s_neg, cull_dec, pass_dec;

   logic signed [YW:0]   a_out_reg [3];
   logic signed [XW:0]   b_out_reg [3];
   logic signed [CW-1:0] c_out_reg [3];
   logic [SW-1:0]        area_reg;
   logic [XW-1:0]        bbxi_reg, bbxf_reg;
   logic [YW-1:0]        bbyi_reg, bbyf_reg;

   // Whole pipeline moves together; only a held result stalls it
   assign adv      = !out_valid_reg || out_ready;
   assign in_ready = adv;

   assign vx[0] = v1[XW+YW-1:YW];
   assign vy[0] = v1[YW-1:0];
   assign vx[1] = v2[XW+YW-1:YW];
   assign vy[1] = v2[YW-1:0];
   assign vx[2] = v3[XW+YW-1:YW];
   assign vy[2] = v3[YW-1:0];

   // Edges (1,2), (2,3), (3,1)
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_edge
         tri_edge_coef #(.XW(XW), .YW(YW)) u_edge (
            .clk (clk),
            .en  (adv),
            .xi  (vx[gi]),
            .yi  (vy[gi]),
            .xj  (vx[(gi+1)%3]),
            .yj  (vy[(gi+1)%3]),
            .a   (a_s2[gi]),
            .b   (b_s2[gi]),
            .c   (c_s2[gi])
         );
      end
   endgenerate

   // Raw bounding box of the incoming vertex set
   always_comb begin
      min_x_next = vx[0];
      max_x_next = vx[0];
      min_y_next = vy[0];
      max_y_next = vy[0];
      for (int i = 1; i < 3; i++) begin
         if (vx[i] < min_x_next) min_x_next = vx[i];
         if (vx[i] > max_x_next) max_x_next = vx[i];
         if (vy[i] < min_y_next) min_y_next = vy[i];
         if (vy[i] > max_y_next) max_y_next = vy[i];
      end
   end

   // Box datapath: raw extents in stage 1, clipped box and off-screen flag in stage 2
   always_ff @(posedge clk) begin
      if (adv) begin
         min_x_reg   <= min_x_next;
         max_x_reg   <= max_x_next;
         min_y_reg   <= min_y_next;
         max_y_reg   <= max_y_next;
         bbxi_s2_reg <= min_x_reg;
         bbyi_s2_reg <= min_y_reg;
         bbxf_s2_reg <= (max_x_reg > X_LAST) ? X_LAST : max_x_reg;
         bbyf_s2_reg <= (max_y_reg > Y_LAST) ? Y_LAST : max_y_reg;
         off_s2_reg  <= ({1'b0, min_x_reg} >= X_LIM) || ({1'b0, min_y_reg} >= Y_LIM);
      end
   end

   // Stage valid bits; a bubble advances like any other slot
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
      end else if (adv) begin
         s1_valid_reg <= in_valid;
         s2_valid_reg <= s1_valid_reg;
      end
   end

   // Orientation from the C sum; zero area and off-screen are always culled
   always_comb begin
      s_sum    = {c_s2[0][CW-1], c_s2[0]} + {c_s2[1][CW-1], c_s2[1]} + {c_s2[2][CW-1], c_s2[2]};
      s_neg    = s_sum[SW-1];
      cull_dec = (s_sum == '0) || off_s2_reg || (s_neg && CULL_BACK);
      pass_dec = s2_valid_reg && !cull_dec;
   end

   // Output register: loaded only with kept triangles, winding normalised to positive
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg  <= 1'b0;
         cull_pulse_reg <= 1'b0;
         cull_count_reg <= '0;
         area_reg       <= '0;
         bbxi_reg       <= '0;
         bbxf_reg       <= '0;
         bbyi_reg       <= '0;
         bbyf_reg       <= '0;
         for (int i = 0; i < 3; i++) begin
            a_out_reg[i] <= '0;
            b_out_reg[i] <= '0;
            c_out_reg[i] <= '0;
         end
      end else if (adv) begin
         out_valid_reg  <= pass_dec;
         cull_pulse_reg <= s2_valid_reg && cull_dec;
         if (s2_valid_reg && cull_dec && cull_count_reg != 16'hFFFF)
            cull_count_reg <= cull_count_reg + 16'd1;
         if (pass_dec) begin
            area_reg <= s_neg ? SW'(-s_sum) : SW'(s_sum);
            bbxi_reg <= bbxi_s2_reg;
            bbxf_reg <= bbxf_s2_reg;
            bbyi_reg <= bbyi_s2_reg;
            bbyf_reg <= bbyf_s2_reg;
            for (int i = 0; i < 3; i++) begin
               a_out_reg[i] <= s_neg ? -a_s2[i] : a_s2[i];
               b_out_reg[i] <= s_neg ? -b_s2[i] : b_s2[i];
               c_out_reg[i] <= s_neg ? -c_s2[i] : c_s2[i];
            end
         end
      end else begin
         cull_pulse_reg <= 1'b0;
      end
   end

   assign out_valid  = out_valid_reg;
   assign cull_pulse = cull_pulse_reg;
   assign cull_count = cull_count_reg;
   assign a1 = a_out_reg[0];
   assign a2 = a_out_reg[1];
   assign a3 = a_out_reg[2];
   assign b1 = b_out_reg[0];
   assign b2 = b_out_reg[1];
   assign b3 = b_out_reg[2];
   assign c1 = c_out_reg[0];
   assign c2 = c_out_reg[1];
   assign c3 = c_out_reg[2];
   assign area2 = area_reg;
   assign bbxi  = bbxi_reg;
   assign bbxf  = bbxf_reg;
   assign bbyi  = bbyi_reg;
   assign bbyf  = bbyf_reg;

endmodule

// File: tb/tb_tri_setup.sv
// Bench for tri_setup: table of hand-computed triangles, a scoreboard queue
// filled at acceptance and drained by an output monitor, plus directed
// sequences for winding negation, backpressure and reset during traffic.
module tb_tri_setup;
   import gpu_pkg::*;

   localparam int XW = XW_DEF;
   localparam int YW = YW_DEF;
   localparam int SNAPW = 3*(YW+1) + 3*(XW+1) + 3*(XW+YW+1) + (XW+YW+2) + 2*XW + 2*YW;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [XW+YW-1:0] v1, v2, v3;
   logic in_valid, out_ready, in_valid0;

   logic in_ready, out_valid, cull_pulse;
   logic signed [YW:0] a1, a2, a3;
   logic signed [XW:0] b1, b2, b3;
   logic signed [XW+YW:0] c1, c2, c3;
   logic [XW+YW+1:0] area2;
   logic [XW-1:0] bbxi, bbxf;
   logic [YW-1:0] bbyi, bbyf;
   logic [15:0] cull_count;

   logic in_ready0, out_valid0, cull_pulse0;
   logic signed [YW:0] a1_0, a2_0, a3_0;
   logic signed [XW:0] b1_0, b2_0, b3_0;
   logic signed [XW+YW:0] c1_0, c2_0, c3_0;
   logic [XW+YW+1:0] area2_0;
   logic [XW-1:0] bbxi_0, bbxf_0;
   logic [YW-1:0] bbyi_0, bbyf_0;
   logic [15:0] cull_count0;

   tri_setup #(.CULL_BACK(1'b1)) dut (
      .clk(clk), .rst(rst), .v1(v1), .v2(v2), .v3(v3),
      .in_valid(in_valid), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .a1(a1), .a2(a2), .a3(a3), .b1(b1), .b2(b2), .b3(b3),
      .c1(c1), .c2(c2), .c3(c3), .area2(area2),
      .bbxi(bbxi), .bbxf(bbxf), .bbyi(bbyi), .bbyf(bbyf),
      .cull_pulse(cull_pulse), .cull_count(cull_count)
   );

   tri_setup #(.CULL_BACK(1'b0)) dut0 (
      .clk(clk), .rst(rst), .v1(v1), .v2(v2), .v3(v3),
      .in_valid(in_valid0), .in_ready(in_ready0),
      .out_valid(out_valid0), .out_ready(1'b1),
      .a1(a1_0), .a2(a2_0), .a3(a3_0), .b1(b1_0), .b2(b2_0), .b3(b3_0),
      .c1(c1_0), .c2(c2_0), .c3(c3_0), .area2(area2_0),
      .bbxi(bbxi_0), .bbxf(bbxf_0), .bbyi(bbyi_0), .bbyf(bbyf_0),
      .cull_pulse(cull_pulse0), .cull_count(cull_count0)
   );

   typedef struct {
      int x1, y1, x2, y2, x3, y3;
      bit cull;
      int a1, a2, a3, b1, b2, b3, c1, c2, c3;
      int area, bxi, bxf, byi, byf;
   } vec_t;

   typedef struct {
      vec_t v;
      int   id;
      int   acc_cyc;
      bit   chk_lat;
   } sb_t;

   sb_t  q[$];
   vec_t tbl[8];

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int exp_culls = 0;
   int n_out = 0;
   int last_out_cyc = 0;
   bit stall_seen = 1'b0;
   bit prev_stall = 1'b0;
   logic [SNAPW-1:0] snap, prev_snap;

   assign snap = {a1, a2, a3, b1, b2, b3, c1, c2, c3, area2, bbxi, bbxf, bbyi, bbyf};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int id, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s vec %0d: got %0d, want %0d", nm, id, act, exp);
      end
   endtask

   function automatic logic [XW+YW-1:0] pk(input int x, input int y);
      return {x[XW-1:0], y[YW-1:0]};
   endfunction

   // Integer reference model of the setup arithmetic
   function automatic vec_t model(input int x1, y1, x2, y2, x3, y3, input bit cull_back);
      vec_t r;
      int s, mnx, mxx, mny, mxy;
      bit off;
      r.x1 = x1; r.y1 = y1; r.x2 = x2; r.y2 = y2; r.x3 = x3; r.y3 = y3;
      r.a1 = y1 - y2; r.a2 = y2 - y3; r.a3 = y3 - y1;
      r.b1 = x2 - x1; r.b2 = x3 - x2; r.b3 = x1 - x3;
      r.c1 = x1*y2 - x2*y1; r.c2 = x2*y3 - x3*y2; r.c3 = x3*y1 - x1*y3;
      s = r.c1 + r.c2 + r.c3;
      mnx = x1; mxx = x1; mny = y1; mxy = y1;
      if (x2 < mnx) mnx = x2; if (x3 < mnx) mnx = x3;
      if (x2 > mxx) mxx = x2; if (x3 > mxx) mxx = x3;
      if (y2 < mny) mny = y2; if (y3 < mny) mny = y3;
      if (y2 > mxy) mxy = y2; if (y3 > mxy) mxy = y3;
      off = (mnx >= SCREEN_W_DEF) || (mny >= SCREEN_H_DEF);
      r.cull = (s == 0) || off || (s < 0 && cull_back);
      if (s < 0) begin
         r.a1 = -r.a1; r.a2 = -r.a2; r.a3 = -r.a3;
         r.b1 = -r.b1; r.b2 = -r.b2; r.b3 = -r.b3;
         r.c1 = -r.c1; r.c2 = -r.c2; r.c3 = -r.c3;
      end
      r.area = (s < 0) ? -s : s;
      r.bxi = mnx; r.byi = mny;
      r.bxf = (mxx > SCREEN_W_DEF-1) ? SCREEN_W_DEF-1 : mxx;
      r.byf = (mxy > SCREEN_H_DEF-1) ? SCREEN_H_DEF-1 : mxy;
      return r;
   endfunction

   // Output monitor: pops the scoreboard on every delivered or culled triangle
   always @(negedge clk) begin
      sb_t e;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (out_valid && cull_pulse) chk("valid_and_pulse", -1, 1, 0);
         if (prev_stall) begin
            n_cmp++;
            if (snap !== prev_snap) begin
               n_fail++;
               $display("FAIL hold_stable: got %h, want %h", snap, prev_snap);
            end
         end
         if ((out_valid && out_ready) || cull_pulse) begin
            if (q.size() == 0) begin
               chk("unexpected_output", -1, 1, 0);
            end else begin
               e = q.pop_front();
               chk("culled", e.id, int'(cull_pulse), int'(e.v.cull));
               if (out_valid && !e.v.cull) begin
                  chk("a1", e.id, int'(a1), e.v.a1);
                  chk("a2", e.id, int'(a2), e.v.a2);
                  chk("a3", e.id, int'(a3), e.v.a3);
                  chk("b1", e.id, int'(b1), e.v.b1);
                  chk("b2", e.id, int'(b2), e.v.b2);
                  chk("b3", e.id, int'(b3), e.v.b3);
                  chk("c1", e.id, int'(c1), e.v.c1);
                  chk("c2", e.id, int'(c2), e.v.c2);
                  chk("c3", e.id, int'(c3), e.v.c3);
                  chk("area2", e.id, int'(area2), e.v.area);
                  chk("bbxi", e.id, int'(bbxi), e.v.bxi);
                  chk("bbxf", e.id, int'(bbxf), e.v.bxf);
                  chk("bbyi", e.id, int'(bbyi), e.v.byi);
                  chk("bbyf", e.id, int'(bbyf), e.v.byf);
               end
               if (cull_pulse) begin
                  if (exp_culls < 65535) exp_culls++;
                  chk("cull_count", e.id, int'(cull_count), exp_culls);
               end
               if (e.chk_lat) chk("latency", e.id, cyc - e.acc_cyc, 3);
               $display("out vec %0d: cull=%0d area2=%0d box x %0d..%0d y %0d..%0d",
                        e.id, cull_pulse, area2, bbxi, bbxf, bbyi, bbyf);
            end
            last_out_cyc = cyc;
            n_out++;
         end
         if (!in_ready) stall_seen = 1'b1;
         prev_stall = out_valid && !out_ready;
         prev_snap  = snap;
      end
   end

   // Present a vertex set until accepted; scoreboard entry pushed at acceptance
   task automatic send(input vec_t v, input int id, input bit lat, output int acc_cyc);
      sb_t s;
      bit acc = 1'b0;
      int n = 0;
      acc_cyc = 0;
      v1 = pk(v.x1, v.y1);
      v2 = pk(v.x2, v.y2);
      v3 = pk(v.x3, v.y3);
      in_valid = 1'b1;
      while (!acc) begin
         @(negedge clk);
         if (in_ready) begin
            s.v = v; s.id = id; s.acc_cyc = cyc; s.chk_lat = lat;
            q.push_back(s);
            acc = 1'b1;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
         n++;
         if (!acc && n > 100) begin
            chk("accept_timeout", id, 0, 1);
            acc = 1'b1;
         end
      end
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (q.size() != 0) begin
         chk("drain_timeout", -1, q.size(), 0);
         q.delete();
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int acc, first_acc, out_base;
      in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
      v1 = '0; v2 = '0; v3 = '0;

      // x1 y1 x2 y2 x3 y3 cull | a1 a2 a3 | b1 b2 b3 | c1 c2 c3 | area | box xi xf yi yf
      tbl[0] = '{10, 10, 50, 10, 10, 50, 0, 0, -40, 40, 40, -40, 0, -400, 2400, -400, 1600, 10, 50, 10, 50};
      tbl[1] = '{10, 10, 10, 50, 50, 10, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[2] = '{0, 0, 10, 10, 20, 20, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{300, 200, 400, 230, 310, 250, 0, -30, -20, 50, 100, -90, -10, -11000, 28700, -13000, 4700, 300, 319, 200, 239};
      tbl[4] = '{320, 10, 400, 10, 320, 50, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[5] = '{10, 240, 50, 240, 10, 250, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{0, 0, 100, 0, 0, 100, 0, 0, -100, 100, 100, -100, 0, 0, 10000, 0, 10000, 0, 100, 0, 100};
      tbl[7] = '{319, 239, 0, 239, 319, 0, 0, 0, 239, -239, -319, 319, 0, 76241, -76241, 76241, 76241, 0, 319, 0, 239};

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 0, int'(out_valid), 0);
      chk("rst_cull_pulse", 0, int'(cull_pulse), 0);
      chk("rst_cull_count", 0, int'(cull_count), 0);
      chk("rst_a1", 0, int'(a1), 0);
      chk("rst_c2", 0, int'(c2), 0);
      chk("rst_area2", 0, int'(area2), 0);
      chk("rst_bbxf", 0, int'(bbxf), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Table vectors back to back
      for (int i = 0; i < 8; i++) send(tbl[i], i, 1'b1, acc);
      in_valid = 1'b0;
      drain();
      chk("table_cull_count", 8, int'(cull_count), 4);

      // Back-facing triangle kept and normalised by the CULL_BACK=0 instance
      v = model(10, 10, 10, 50, 50, 10, 1'b0);
      v1 = pk(10, 10); v2 = pk(10, 50); v3 = pk(50, 10);
      in_valid0 = 1'b1;
      @(posedge clk); #1;
      in_valid0 = 1'b0;
      @(negedge clk);
      chk("nb_early1", 20, int'(out_valid0), 0);
      @(posedge clk);
      @(negedge clk);
      chk("nb_early2", 20, int'(out_valid0), 0);
      @(posedge clk);
      @(negedge clk);
      chk("nb_valid", 20, int'(out_valid0), 1);
      chk("nb_pulse", 20, int'(cull_pulse0), 0);
      chk("nb_a1", 20, int'(a1_0), 40);
      chk("nb_a2", 20, int'(a2_0), -40);
      chk("nb_a3", 20, int'(a3_0), 0);
      chk("nb_b1", 20, int'(b1_0), 0);
      chk("nb_b2", 20, int'(b2_0), -40);
      chk("nb_b3", 20, int'(b3_0), 40);
      chk("nb_c1", 20, int'(c1_0), -400);
      chk("nb_c2", 20, int'(c2_0), 2400);
      chk("nb_c3", 20, int'(c3_0), -400);
      chk("nb_area2", 20, int'(area2_0), 1600);
      chk("nb_model_area", 20, int'(area2_0), v.area);
      $display("out nb vec 20: area2=%0d a=(%0d,%0d,%0d)", area2_0, a1_0, a2_0, a3_0);
      @(posedge clk); #1;

      // Stream of six with a five-cycle output stall in the middle
      stall_seen = 1'b0;
      out_base = n_out;
      first_acc = 0;
      fork
         begin
            for (int k = 0; k < 6; k++) begin
               v = model(10+4*k, 10+k, 50+4*k, 10+k, 10+4*k, 50+k, 1'b1);
               send(v, 30+k, 1'b0, acc);
               if (k == 0) first_acc = acc;
            end
            in_valid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      chk("stall_in_ready_low", 30, int'(stall_seen), 1);
      chk("stream_count", 30, n_out - out_base, 6);
      chk("stream_span", 30, last_out_cyc - first_acc, 13);

      // Reset with two triangles in flight discards them
      v = model(10, 10, 50, 10, 10, 50, 1'b1);
      send(v, 40, 1'b0, acc);
      v = model(10, 10, 10, 50, 50, 10, 1'b1);
      send(v, 41, 1'b0, acc);
      rst = 1'b1;
      in_valid = 1'b0;
      q.delete();
      exp_culls = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_cull_count", 41, int'(cull_count), 0);
      repeat (4) @(posedge clk);
      #1;
      v = model(20, 20, 60, 20, 20, 60, 1'b1);
      send(v, 42, 1'b1, acc);
      in_valid = 1'b0;
      drain();
      chk("post_rst_outputs", 42, n_out - out_base, 7);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/tri_setup.md
# tri_setup

Parametrised triangle-setup stage that replaces the fixed 8-bit edge/bounding-box unit. It sits between the vertex transform stage and the rasteriser. Per triangle it produces:
- edge-equation coefficients, normalised so "inside" is always ≥0 regardless of winding;
- the doubled signed area;
- a bounding box clipped to the screen.

It accepts one triangle per cycle through a valid/ready pipeline with backpressure. Back-facing, degenerate and fully off-screen triangles are culled in-line and counted.

## Interface
- XW, default 9: unsigned x coordinate width.
- YW, default 8: unsigned y coordinate width.
- SCREEN_W, default 320: visible width; valid x range is 0..SCREEN_W-1.
- SCREEN_H, default 240: visible height; valid y range is 0..SCREEN_H-1.
- CULL_BACK, default 1: 1 = cull negative-area triangles; 0 = negate their coefficients and keep them.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- v1, v2, v3  in  XW+YW each  vertex packed as {x, y}, both unsigned.
- in_valid  in  1  vertex set valid.
- in_ready  out  1  stage can accept the vertex set.
- out_valid  out  1  setup result valid.
- out_ready  in  1  rasteriser accepts the result.
- a1, a2, a3  out  YW+1 signed  edge A coefficients.
- b1, b2, b3  out  XW+1 signed  edge B coefficients.
- c1, c2, c3  out  XW+YW+1 signed  edge C coefficients.
- area2  out  XW+YW+2 unsigned  doubled absolute area.
- bbxi, bbxf  out  XW  clipped x minimum / maximum.
- bbyi, bbyf  out  YW  clipped y minimum / maximum.
- cull_pulse  out  1  one-cycle pulse per culled triangle.
- cull_count  out  16  saturating count of culled triangles.

## Operation
- Edge i→j, with pairs (1,2), (2,3), (3,1):
  - A = yi − yj
  - B = xj − xi
  - C = xi·yj − xj·yi
- All arithmetic is signed at full width. Inputs are zero-extended before subtraction or multiplication, so nothing overflows (|A| ≤ 2^YW−1, |C| < 2^(XW+YW)).
- S = c1+c2+c3 (XW+YW+2 bits signed).
- Decision on S:
  - S > 0: pass unchanged.
  - S < 0 and CULL_BACK=1: cull.
  - S < 0 and CULL_BACK=0: negate all nine coefficients, then pass.
  - S = 0: cull (degenerate).
- area2 = |S|.
- Bounding box = min/max of the three vertices, then clipped:
  - bbxf = min(max_x, SCREEN_W−1)
  - bbyf = min(max_y, SCREEN_H−1)
  - Minima need no lower clip (coordinates are unsigned).
  - If min_x ≥ SCREEN_W or min_y ≥ SCREEN_H, the triangle is culled (off-screen).
- Culled triangles:
  - never raise out_valid;
  - assert cull_pulse for one cycle as they leave stage 2;
  - increment cull_count, which saturates at 0xFFFF.
- Pipeline has three register stages:
  - S1 registers the latched vertices, A/B values, the six products and the raw min/max.
  - S2 registers C and the clipped box.
  - The output register is loaded from the S2 values combined with the combinational area/orientation/cull decision.
- Global advance: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 0, every stage and its valid bit hold.
  - Bubbles are not squeezed.

## Timing
- Reset, held for one or more edges, forces:
  - all stage valids, out_valid, cull_pulse, in_ready-gating state and cull_count to 0;
  - coefficient, area and box outputs to 0.
- A set accepted at edge N (in_valid & in_ready) leaves the output register at edge N+2. Its result is visible, with out_valid high or cull_pulse high, in the cycle after edge N+2: latency 3 cycles.
- Throughput is one triangle per cycle while out_ready = 1.
- Output fields are stable while out_valid & !out_ready. They change only on the edge after out_ready is sampled high, or during reset.
- A culled triangle at the stage boundary does not wait for out_ready when the output is empty. Its pulse is emitted on the same edge that the output register would have loaded.
- in_ready depends combinationally on out_ready; the interface has no other combinational paths.
- Reset during traffic discards all in-flight triangles; no output or pulse is produced for them.
- A set presented with in_valid while in_ready = 0 is not accepted and must be held by the sender.

## Structure
- gpu_pkg holds:
  - the XW/YW default constants and the SCREEN_W/SCREEN_H defaults;
  - a typedef'd packed vertex struct {x, y};
  - a typedef'd setup-result struct (coefficients, area2, box), so the rasteriser shares it.
- Sub-module tri_edge_coef computes A, B and registered products/C for one edge (two-stage, enable-gated). It is instantiated three times.
- Products are registered before subtraction so DSP inference is retained.

## Test plan
- Keep, CULL_BACK=1: v1=(10,10), v2=(50,10), v3=(10,50) → after 3 cycles:
  - a=(0,−40,40), b=(40,−40,0), c=(−400,2400,−400);
  - area2=1600;
  - box x 10..50, y 10..50.
- Swap v2/v3:
  - CULL_BACK=1 → cull_pulse=1, no out_valid, cull_count=1.
  - CULL_BACK=0 → negated coefficients, area2=1600.
- Degenerate (0,0),(10,10),(20,20) → culled.
- Clip and off-screen:
  - (300,200),(400,230),(310,250) → bbxf=319, bbyf=239, passed.
  - All x ≥ 320 → culled.
- Backpressure: stream 6 triangles with out_ready low for 5 cycles mid-stream:
  - in_ready falls;
  - outputs hold stable;
  - all 6 emerge in order with no duplicates;
  - 1/cycle resumes afterwards.
- Reset after 2 accepted triangles → no out_valid or cull_pulse for them; cull_count=0; the next triangle has latency 3.
